register_file_wb: RTL

- MIPS register file sitting directly downstream of the write-register select mux.
- The mux chooses rt, rd, or 31 for JAL; its output drives WriteRegister here. WriteData comes from the write-back mux (ALU result, memory data, or PC+4 on JAL).
- Two combinational read ports feed the ALU operand path.
- One synchronous write port commits at the end of each single-cycle instruction.

---
 rtl/mips_regs_pkg.sv | 14 +
 rtl/register_cell.sv | 32 +++
 rtl/register_file_wb.sv | 69 ++++++
 3 files changed

// File: rtl/mips_regs_pkg.sv
// Shared MIPS register-file constants.
// Holds the architectural register indices the datapath refers to by name, and
// the default reset values of the stack and global pointers.
package mips_regs_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_GP   = 28;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage

// File: rtl/register_cell.sv
// One storage register of the MIPS register file.
// Ports:
//   clk_i   - rising-edge clock
//   reset_i - synchronous active-high reset, loads RESET_VALUE
//   en_i    - write enable, loads d_i on the edge
//   d_i     - write data
//   q_o     - stored value
module register_cell #(
  parameter int unsigned          NBits       = 32,
  parameter logic [NBits-1:0]     RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [NBits-1:0] d_i,
  output logic [NBits-1:0] q_o
);

  logic [NBits-1:0] q_q;

  // Reset has priority, so a write pending on the same edge is discarded.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RESET_VALUE;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file_wb.sv
// MIPS register file fed by the write-register select mux and write-back mux.
// Two combinational read ports, one synchronous write port. r0 is hard-wired
// to zero and never stored; $gp and $sp come out of reset at their init values.
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous active-high reset, overrides RegWrite
//   RegWrite      - write enable from control
//   WriteRegister - destination index (rt, rd or 31 for JAL)
//   WriteData     - value committed on the edge
//   ReadRegister1 - rs index;  ReadData1 - its contents
//   ReadRegister2 - rt index;  ReadData2 - its contents
module register_file_wb
  import mips_regs_pkg::*;
#(
  parameter int unsigned      NBits   = 32,
  parameter int unsigned      NAddr   = 5,
  parameter bit               BYPASS  = 1'b0,
  parameter logic [NBits-1:0] SP_INIT = NBits'(SP_INIT_DEFAULT),
  parameter logic [NBits-1:0] GP_INIT = NBits'(GP_INIT_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [NAddr-1:0] WriteRegister,
  input  logic [NBits-1:0] WriteData,
  input  logic [NAddr-1:0] ReadRegister1,
  input  logic [NAddr-1:0] ReadRegister2,
  output logic [NBits-1:0] ReadData1,
  output logic [NBits-1:0] ReadData2
);

  localparam int unsigned NumRegs = 2 ** NAddr;

  logic [NBits-1:0] regs [NumRegs];

  assign regs[REG_ZERO] = '0;

  // No cell exists for r0, so writes to it are dropped without extra gating.
  for (genvar i = 1; i < NumRegs; i++) begin : g_cell
    localparam logic [NBits-1:0] ResetValue = (i == REG_SP) ? SP_INIT :
                                              (i == REG_GP) ? GP_INIT : '0;
    logic wr_en;
    assign wr_en = RegWrite & (WriteRegister == NAddr'(i));

    register_cell #(
      .NBits       (NBits),
      .RESET_VALUE (ResetValue)
    ) u_cell (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (wr_en),
      .d_i     (WriteData),
      .q_o     (regs[i])
    );
  end

  // Forwarding is only meaningful for a write that will actually commit.
  logic wr_live;
  logic byp1;
  logic byp2;

  assign wr_live = BYPASS & RegWrite & ~reset & (WriteRegister != '0);
  assign byp1    = wr_live & (ReadRegister1 == WriteRegister);
  assign byp2    = wr_live & (ReadRegister2 == WriteRegister);

  assign ReadData1 = byp1 ? WriteData : regs[ReadRegister1];
  assign ReadData2 = byp2 ? WriteData : regs[ReadRegister2];

endmodule
